// File: rtl/rv32i_inst_encode_pkg.sv
// rv32i_inst_encode_pkg: RV32I formats, opcodes and immediate range helper shared by the encoder
package rv32i_inst_encode_pkg;

   typedef logic [31:0] rv32i_inst_t;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } inst_fmt_t;

   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_LUI    = 7'h37;

   // True when v[31:lsb] are all copies of the sign bit, i.e. v is representable
   // as a signed field whose top bit sits at position lsb.
   function automatic logic sext_fits(input logic [31:0] v, input int unsigned lsb);
      logic signed [31:0] s;
      s = $signed(v) >>> lsb;
      return (s == '0) || (s == '1);
   endfunction

endpackage

// File: rtl/rv32i_inst_encode_fmt_pack.sv
// rv32i_fmt_pack: combinational packer of RV32I fields and immediate into one instruction word
//   fmt/opcode/funct3/funct7/rd/rs1/rs2/imm : instruction fields, imm as full signed value
//   inst : packed word (raw, even when err is set)
//   err  : immediate out of range, misaligned, or unknown format
module rv32i_fmt_pack
   import rv32i_inst_encode_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output rv32i_inst_t inst,
   output logic        err
);

   always_comb begin
      inst = '0;
      err  = 1'b0;
      case (fmt)
         FMT_R: inst = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I: begin
            inst = {imm[11:0], rs1, funct3, rd, opcode};
            err  = !sext_fits(imm, 11);
         end
         FMT_S: begin
            inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            err  = !sext_fits(imm, 11);
         end
         FMT_B: begin
            inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            err  = !sext_fits(imm, 12) || imm[0];
         end
         FMT_U: begin
            inst = {imm[31:12], rd, opcode};
            err  = |imm[11:0];
         end
         FMT_J: begin
            inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            err  = !sext_fits(imm, 20) || imm[0];
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/rv32i_inst_encode.sv
// rv32i_inst_encode: two-stage valid/ready RV32I instruction encoder with saturating error count
//   req_* : request handshake and instruction fields (req_rdy combinational from rsp_rdy)
//   rsp_* : response handshake, encoded instruction and error flag
//   err_cnt : saturating count of errored responses accepted downstream
module rv32i_inst_encode
   import rv32i_inst_encode_pkg::*;
#(
   parameter int ERR_CNT_W   = 16,
   parameter bit ZERO_ON_ERR = 1'b1
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_vld,
   output logic                 req_rdy,
   input  logic [2:0]           req_fmt,
   input  logic [6:0]           req_opcode,
   input  logic [2:0]           req_funct3,
   input  logic [6:0]           req_funct7,
   input  logic [4:0]           req_rd,
   input  logic [4:0]           req_rs1,
   input  logic [4:0]           req_rs2,
   input  logic [31:0]          req_imm,
   output logic                 rsp_vld,
   input  logic                 rsp_rdy,
   output rv32i_inst_t          rsp_inst,
   output logic                 rsp_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   logic        s1_vld, s2_vld, s1_adv, s2_adv;
   logic [2:0]  s1_fmt, s1_funct3;
   logic [6:0]  s1_opcode, s1_funct7;
   logic [4:0]  s1_rd, s1_rs1, s1_rs2;
   logic [31:0] s1_imm;
   rv32i_inst_t pk_inst;
   logic        pk_err;

   // Each stage moves when its successor is empty or being drained this cycle.
   assign s2_adv  = !s2_vld || rsp_rdy;
   assign s1_adv  = !s1_vld || s2_adv;
   assign req_rdy = s1_adv;
   assign rsp_vld = s2_vld;

   always_ff @(posedge clk) begin
      if (req_vld && s1_adv) begin
         s1_fmt    <= req_fmt;
         s1_opcode <= req_opcode;
         s1_funct3 <= req_funct3;
         s1_funct7 <= req_funct7;
         s1_rd     <= req_rd;
         s1_rs1    <= req_rs1;
         s1_rs2    <= req_rs2;
         s1_imm    <= req_imm;
      end
   end

   rv32i_fmt_pack u_pack (
      .fmt    (s1_fmt),
      .opcode (s1_opcode),
      .funct3 (s1_funct3),
      .funct7 (s1_funct7),
      .rd     (s1_rd),
      .rs1    (s1_rs1),
      .rs2    (s1_rs2),
      .imm    (s1_imm),
      .inst   (pk_inst),
      .err    (pk_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld   <= 1'b0;
         s2_vld   <= 1'b0;
         rsp_inst <= '0;
         rsp_err  <= 1'b0;
         err_cnt  <= '0;
      end else begin
         if (s1_adv)
            s1_vld <= req_vld;
         if (s2_adv)
            s2_vld <= s1_vld;
         if (s2_adv && s1_vld) begin
            rsp_inst <= (pk_err && ZERO_ON_ERR) ? '0 : pk_inst;
            rsp_err  <= pk_err;
         end
         if (rsp_vld && rsp_rdy && rsp_err && !(&err_cnt))
            err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_rv32i_inst_encode.sv
// tb_rv32i_inst_encode: directed and randomized self-checking bench for rv32i_inst_encode
module tb_rv32i_inst_encode;
   import rv32i_inst_encode_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_vld = 1'b0;
   logic        req_rdy, req_rdy2;
   logic [2:0]  req_fmt = 3'd0;
   logic [6:0]  req_opcode = 7'd0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [6:0]  req_funct7 = 7'd0;
   logic [4:0]  req_rd = 5'd0;
   logic [4:0]  req_rs1 = 5'd0;
   logic [4:0]  req_rs2 = 5'd0;
   logic [31:0] req_imm = 32'd0;
   logic        rsp_vld, rsp_vld2;
   logic        rsp_rdy = 1'b0;
   logic [31:0] rsp_inst, rsp_inst2;
   logic        rsp_err, rsp_err2;
   logic [15:0] err_cnt;
   logic [1:0]  err_cnt2;

   int checks = 0;
   int errors = 0;
   int model_cnt = 0;

   typedef struct {
      logic [2:0]  fmt;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        has_ex;
      logic [31:0] ex;
   } ent_t;

   ent_t        q[$];
   ent_t        mon_e;
   logic        mon_ee;
   logic        nxt_has = 1'b0;
   logic [31:0] nxt_ex = 32'd0;
   logic        rnd_bp = 1'b0;
   logic        prev_hold = 1'b0;
   logic [31:0] prev_inst = 32'd0;
   logic        prev_err = 1'b0;
   int          w;

   always #5 clk = ~clk;

   rv32i_inst_encode #(.ERR_CNT_W(16), .ZERO_ON_ERR(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy),
      .req_fmt(req_fmt), .req_opcode(req_opcode), .req_funct3(req_funct3),
      .req_funct7(req_funct7), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
      .req_imm(req_imm), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_inst(rsp_inst),
      .rsp_err(rsp_err), .err_cnt(err_cnt)
   );

   rv32i_inst_encode #(.ERR_CNT_W(2), .ZERO_ON_ERR(1'b1)) dut2 (
      .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy2),
      .req_fmt(req_fmt), .req_opcode(req_opcode), .req_funct3(req_funct3),
      .req_funct7(req_funct7), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
      .req_imm(req_imm), .rsp_vld(rsp_vld2), .rsp_rdy(rsp_rdy), .rsp_inst(rsp_inst2),
      .rsp_err(rsp_err2), .err_cnt(err_cnt2)
   );

   // Legal ranges stated as plain signed arithmetic.
   function automatic logic model_err(input logic [2:0] f, input logic [31:0] v);
      int s;
      s = $signed(v);
      case (f)
         3'd0: return 1'b0;
         3'd1, 3'd2: return (s < -2048) || (s > 2047);
         3'd3: return (s < -4096) || (s > 4094) || (s % 2 != 0);
         3'd4: return (v % 4096) != 0;
         3'd5: return (s < -1048576) || (s > 1048574) || (s % 2 != 0);
         default: return 1'b1;
      endcase
   endfunction

   // Decode the word back with the core's field extractors and immediate decoders.
   function automatic logic fields_ok(input ent_t e, input logic [31:0] x);
      logic [31:0] di, ds, db, du, dj;
      logic op_ok, rd_ok, f3_ok, rs1_ok, rs2_ok;
      di = {{20{x[31]}}, x[31:20]};
      ds = {{20{x[31]}}, x[31:25], x[11:7]};
      db = {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
      du = {x[31:12], 12'b0};
      dj = {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
      op_ok  = x[6:0] == e.op;
      rd_ok  = x[11:7] == e.rd;
      f3_ok  = x[14:12] == e.f3;
      rs1_ok = x[19:15] == e.rs1;
      rs2_ok = x[24:20] == e.rs2;
      case (e.fmt)
         3'd0: return op_ok && rd_ok && f3_ok && rs1_ok && rs2_ok && (x[31:25] == e.f7);
         3'd1: return op_ok && rd_ok && f3_ok && rs1_ok && (di == e.imm);
         3'd2: return op_ok && f3_ok && rs1_ok && rs2_ok && (ds == e.imm);
         3'd3: return op_ok && f3_ok && rs1_ok && rs2_ok && (db == e.imm);
         3'd4: return op_ok && rd_ok && (du == e.imm);
         3'd5: return op_ok && rd_ok && (dj == e.imm);
         default: return 1'b0;
      endcase
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         model_cnt = 0;
         prev_hold = 1'b0;
      end else begin
         checks++;
         assert (err_cnt === 16'(model_cnt > 65535 ? 65535 : model_cnt)) else begin
            errors++; $error("FAIL err_cnt got %0d exp %0d", err_cnt, model_cnt);
         end
         checks++;
         assert (err_cnt2 === 2'(model_cnt > 3 ? 3 : model_cnt)) else begin
            errors++; $error("FAIL err_cnt_sat got %0d exp %0d", err_cnt2, (model_cnt > 3 ? 3 : model_cnt));
         end
         if (prev_hold) begin
            checks++;
            assert (rsp_vld === 1'b1 && rsp_inst === prev_inst && rsp_err === prev_err) else begin
               errors++; $error("FAIL rsp_hold got %b/%h exp 1/%h", rsp_vld, rsp_inst, prev_inst);
            end
         end
         prev_hold = rsp_vld && !rsp_rdy;
         prev_inst = rsp_inst;
         prev_err  = rsp_err;
         if (rsp_vld && rsp_rdy) begin
            checks++;
            assert (q.size() != 0) else begin
               errors++; $error("FAIL unexpected_rsp got %h exp none", rsp_inst);
            end
            if (q.size() != 0) begin
               mon_e  = q.pop_front();
               mon_ee = model_err(mon_e.fmt, mon_e.imm);
               checks++;
               assert (rsp_err === mon_ee) else begin
                  errors++; $error("FAIL rsp_err got %b exp %b fmt %0d imm %h", rsp_err, mon_ee, mon_e.fmt, mon_e.imm);
               end
               if (mon_ee) begin
                  model_cnt++;
                  checks++;
                  assert (rsp_inst === 32'h0) else begin
                     errors++; $error("FAIL err_zero got %h exp 00000000", rsp_inst);
                  end
               end else begin
                  checks++;
                  assert (fields_ok(mon_e, rsp_inst)) else begin
                     errors++; $error("FAIL roundtrip got %h exp fmt %0d imm %h", rsp_inst, mon_e.fmt, mon_e.imm);
                  end
               end
               if (mon_e.has_ex) begin
                  checks++;
                  assert (rsp_inst === mon_e.ex) else begin
                     errors++; $error("FAIL exact got %h exp %h", rsp_inst, mon_e.ex);
                  end
               end
            end
         end
         if (req_vld && req_rdy)
            q.push_back('{req_fmt, req_opcode, req_funct3, req_funct7, req_rd, req_rs1,
                          req_rs2, req_imm, nxt_has, nxt_ex});
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++; $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic ex,
                        input logic [31:0] exv);
      req_fmt    = f;
      req_opcode = op;
      req_funct3 = f3;
      req_funct7 = f7;
      req_rd     = rd;
      req_rs1    = rs1;
      req_rs2    = rs2;
      req_imm    = imm;
      nxt_has    = ex;
      nxt_ex     = exv;
      req_vld    = 1'b1;
   endtask

   // Returns at posedge+1 of the accepting edge; n counts refused cycles.
   task automatic wait_acc(output int n);
      logic got;
      got = 1'b0;
      n = 0;
      while (!got && n < 200) begin
         @(negedge clk);
         got = req_rdy;
         @(posedge clk);
         #1;
         if (rnd_bp) rsp_rdy = ($urandom_range(0, 3) != 0);
         if (!got) n++;
      end
      checks++;
      assert (got) else begin
         errors++; $error("FAIL accept_timeout got 0 exp 1");
      end
   endtask

   task automatic wait_empty();
      int n;
      n = 0;
      while (q.size() != 0 && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      assert (q.size() == 0) else begin
         errors++; $error("FAIL drain_timeout got %0d exp 0", q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_req(input logic wild);
      logic [2:0]  f;
      logic [31:0] v;
      f = wild ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 5));
      case (f)
         3'd1, 3'd2: v = $urandom_range(0, 4095) - 2048;
         3'd3: v = ($urandom_range(0, 4095) - 2048) * 2;
         3'd4: v = $urandom & 32'hFFFFF000;
         3'd5: v = ($urandom_range(0, 1048575) - 524288) * 2;
         default: v = $urandom;
      endcase
      if (wild) v = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 8191) - 4096;
      drive(f, 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
            5'($urandom), v, 1'b0, 32'h0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
      chk("rst_rsp_inst", rsp_inst, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_req_rdy", {31'd0, req_rdy}, 32'd1);
      chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
      rsp_rdy = 1'b1;
      drive(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF00093);
      wait_acc(w);
      req_vld = 1'b0;
      chk("lat_n1", {31'd0, rsp_vld}, 32'd0);
      @(posedge clk);
      #1;
      chk("lat_n2", {31'd0, rsp_vld}, 32'd1);
      drive(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 32'h0);
      wait_acc(w);
      drive(FMT_S, OPC_STORE, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0020A423);
      wait_acc(w);
      drive(FMT_U, OPC_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h123452B7);
      wait_acc(w);
      drive(FMT_U, OPC_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345001, 1'b1, 32'h0);
      wait_acc(w);
      drive(FMT_J, OPC_JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b1, 32'hFFDFF06F);
      wait_acc(w);
      drive(FMT_B, OPC_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b1, 32'h0);
      wait_acc(w);
      drive(FMT_B, OPC_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd4096, 1'b1, 32'h0);
      wait_acc(w);
      req_vld = 1'b0;
      wait_empty();
      chk("err_cnt_4", {16'd0, err_cnt}, 32'd4);
      chk("err_cnt_sat3", {30'd0, err_cnt2}, 32'd3);
      drive(FMT_I, OPC_LOAD, 3'd2, 7'd0, 5'd3, 5'd4, 5'd0, 32'd2047, 1'b0, 32'h0);
      wait_acc(w);
      drive(FMT_I, OPC_LOAD, 3'd2, 7'd0, 5'd3, 5'd4, 5'd0, 32'hFFFFF800, 1'b0, 32'h0);
      wait_acc(w);
      drive(FMT_I, OPC_LOAD, 3'd2, 7'd0, 5'd3, 5'd4, 5'd0, 32'hFFFFF7FF, 1'b0, 32'h0);
      wait_acc(w);
      drive(FMT_B, OPC_BRANCH, 3'd1, 7'd0, 5'd0, 5'd7, 5'd8, 32'hFFFFF000, 1'b0, 32'h0);
      wait_acc(w);
      drive(FMT_B, OPC_BRANCH, 3'd1, 7'd0, 5'd0, 5'd7, 5'd8, 32'd4094, 1'b0, 32'h0);
      wait_acc(w);
      drive(FMT_J, OPC_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1048574, 1'b0, 32'h0);
      wait_acc(w);
      drive(FMT_J, OPC_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1048576, 1'b0, 32'h0);
      wait_acc(w);
      drive(FMT_R, OPC_OP, 3'd5, 7'h20, 5'd9, 5'd10, 5'd11, 32'h0, 1'b1, 32'h40B554B3);
      wait_acc(w);
      drive(3'd6, OPC_OP, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'h0, 1'b1, 32'h0);
      wait_acc(w);
      req_vld = 1'b0;
      wait_empty();
      rsp_rdy = 1'b0;
      drive(FMT_R, OPC_OP, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 32'h0);
      wait_acc(w);
      drive(FMT_R, OPC_OP, 3'd1, 7'd0, 5'd4, 5'd5, 5'd6, 32'h0, 1'b0, 32'h0);
      wait_acc(w);
      drive(FMT_R, OPC_OP, 3'd2, 7'd0, 5'd7, 5'd8, 5'd9, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      chk("bp_req_rdy", {31'd0, req_rdy}, 32'd0);
      @(posedge clk);
      #1 rsp_rdy = 1'b1;
      wait_acc(w);
      for (int i = 0; i < 20; i++) begin
         rand_req(1'b0);
         wait_acc(w);
         chk("stream_stall", w, 32'd0);
      end
      req_vld = 1'b0;
      wait_empty();
      rsp_rdy = 1'b0;
      drive(FMT_S, OPC_STORE, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd4, 1'b0, 32'h0);
      wait_acc(w);
      drive(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5000, 1'b0, 32'h0);
      wait_acc(w);
      req_vld = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_rsp_vld", {31'd0, rsp_vld}, 32'd0);
      chk("rst_mid_err_cnt", {16'd0, err_cnt}, 32'd0);
      chk("rst_mid_err_cnt2", {30'd0, err_cnt2}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rsp_rdy = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_no_stale", {31'd0, rsp_vld}, 32'd0);
      rnd_bp = 1'b1;
      for (int i = 0; i < 11200; i++) begin
         rand_req(i % 10 == 9);
         wait_acc(w);
      end
      req_vld = 1'b0;
      rnd_bp = 1'b0;
      rsp_rdy = 1'b1;
      wait_empty();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv32i_inst_encode.md
Name: rv32i_inst_encode

Overview:
Pipelined RV32I instruction encoder, the inverse of the core's immediate decoders. It packs format, opcode, function, register and immediate fields into a 32-bit rv32i_inst_t word, range- and alignment-checking the immediate. It serves the debug module's program buffer and the trap-stub generator. Valid/ready request and response interfaces, two-stage pipeline, full throughput.

Parameters:
ERR_CNT_W, 16, width of saturating error counter
ZERO_ON_ERR, 1, 1: rsp_inst forced to 32'h0 on error; 0: truncated encoding emitted

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_vld  input  1  request valid
req_rdy  output  1  request ready
req_fmt  input  3  inst_fmt_t: R, I, S, B, U, J
req_opcode  input  7  opcode field
req_funct3  input  3  funct3 (ignored for U/J)
req_funct7  input  7  funct7 (R only)
req_rd  input  5  rd (ignored for S/B)
req_rs1  input  5  rs1 (ignored for U/J)
req_rs2  input  5  rs2 (R/S/B only)
req_imm  input  32  full signed immediate value (U: full 32-bit value)
rsp_vld  output  1  response valid
rsp_rdy  input  1  response ready
rsp_inst  output  32  encoded instruction
rsp_err  output  1  immediate out of range, misaligned, or illegal fmt
err_cnt  output  ERR_CNT_W  saturating count of errored responses

Behaviour:
- Clock clk, reset rst_n: asynchronous, active-low. Reset clears s1_vld, s2_vld, err_cnt; rsp_vld=0, rsp_inst=0, rsp_err=0, req_rdy=1 once reset deasserts.
- Handshake: transfer when vld&&rdy. vld must not drop and payload must not change until accepted (bench asserts on req side; DUT guarantees on rsp side).
- Stage S1: registers request fields, computes err and per-format packed fields.
- Stage S2: output register driving rsp_*.
- s2_adv = !s2_vld || rsp_rdy; s1_adv = !s1_vld || s2_adv; req_rdy = s1_adv (combinational from rsp_rdy, permitted).
- Latency: accept in cycle N, rsp_vld in cycle N+2 when not stalled. Throughput 1/cycle. Order preserved, no drop or duplication under any backpressure.
- Range and error rules, with imm = req_imm as signed 32-bit:
  - I, S: err unless imm[31:11] all equal (range -2048..2047).
  - B: err unless imm[31:12] all equal and imm[0]==0 (range -4096..4094).
  - J: err unless imm[31:20] all equal and imm[0]==0.
  - U: err unless imm[11:0]==0.
  - R: imm ignored, never err.
  - fmt codes 6 and 7: err.
- Packing is the exact inverse of the core's immediate field layout. Examples: J places imm[20|10:1|11|19:12] in inst[31:12]; B places imm[12|10:5] in inst[31:25] and imm[4:1|11] in inst[11:7].
- On err with ZERO_ON_ERR=1, rsp_inst=0 (architecturally illegal).
- err_cnt increments on each rsp handshake with rsp_err=1 and saturates at all-ones; it does not wrap.
- Simultaneous S2 drain and S1 refill in one cycle is legal and required for full throughput.
- Reset mid-operation discards in-flight entries. No response is produced for them.

Decomposition:
- Shared package isa.svh gains:
  - inst_fmt_t enum (R=0, I=1, S=2, B=3, U=4, J=5).
  - Opcode constants: OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_LUI.
- Sub-module rv32i_fmt_pack: purely combinational, maps fmt+fields+imm to {inst[31:0], err}. It is instantiated between S1 and S2 and is reusable by the debug program-buffer generator.

Test Plan:
- I: opcode 0x13, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF -> rsp_inst=0xFFF00093, err=0; I with imm=2048 -> inst=0, err=1, err_cnt=1.
- S: opcode 0x23, f3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423. U: opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7; U imm=0x12345001 -> err.
- J: opcode 0x6F, rd=0, imm=-4 -> 0xFFDFF06F. B imm=3 -> err, inst=0. B imm=4096 -> err.
- Backpressure:
  - Hold rsp_rdy=0 and issue 3 back-to-back requests: req_rdy drops after 2 accepts.
  - Release rsp_rdy: all 3 responses arrive in order, then 1/cycle streaming resumes.
- Reset asserted with both stages full -> rsp_vld=0 immediately, err_cnt=0, no stale response after release.
- Random round-trip, ≥10k legal requests: decoding rsp_inst with the core's i/s/b/j immediate decoders returns req_imm. err_cnt saturation checked with ERR_CNT_W=2 (stays 3).
